clk_en_gen: RTL and testbench

Parametrised N-channel fractional clock-enable generator with a PLL lock-qualified start-up sequencer. It runs in the PLL output clock domain. It waits until the PLL lock indication has been stable for a programmable time, then produces per-channel one-cycle enable pulses at rates of f_clk·inc/2^ACC_W. Per-channel rates can be reprogrammed at runtime through a valid/ready port without glitches. Downstream logic (video timing, audio sample strobes, TM1638 scan) uses these enables instead of extra PLL outputs.

---
 rtl/clk_en_gen_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/clk_en_gen.sv | 151 +++++++++++++++
 tb/tb_clk_en_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Included by clk_en_gen and by anything that needs rate constants at elaboration.
package clk_en_gen_pkg;

  localparam int ACC_W_DEF = 24;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Elaboration-time rate helper: nearest increment giving f_out from f_clk.
  function automatic longint unsigned inc_for_freq(input real f_out_hz,
                                                   input real f_clk_hz,
                                                   input int unsigned acc_w);
    return longint'(f_out_hz * (2.0 ** acc_w) / f_clk_hz);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for slow, level-type signals crossing into clk.
module sync_2ff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: sequential state always uses non-blocking assignments so both flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// N-channel fractional clock-enable generator gated by a PLL-lock start-up sequencer.
// Optional square-wave outputs sq_o are built when CLK_EN_GEN_SQUARE_EN is defined.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int                    N_CH        = 2,
  parameter int                    ACC_W       = ACC_W_DEF,
  parameter int                    LOCK_STABLE = 1024,
  parameter logic [N_CH*ACC_W-1:0] INC_INIT    = {N_CH{{1'b1, {(ACC_W-1){1'b0}}}}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [N_CH-1:0]   en_o,
  output logic              ready_o,
  output logic              lock_lost_o
`ifdef CLK_EN_GEN_SQUARE_EN
  ,
  output logic [N_CH-1:0]   sq_o
`endif
);

  localparam int                CNT_W     = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [CNT_W-1:0]  STAB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]        N_CH_L    = 4'(N_CH);

  logic             lock_s;
  state_e           state, state_nxt;
  logic [CNT_W-1:0] stab_cnt;
  logic             run;

  logic             pend_v;
  logic [2:0]       pend_ch;
  logic [ACC_W-1:0] pend_inc;
  logic [N_CH-1:0]  apply;

  sync_2ff #(.W(1), .RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // ---------------- start-up sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_LOCK;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_LOCK: if (lock_s) state_nxt = STABLE;
      STABLE: begin
        if (!lock_s)                    state_nxt = WAIT_LOCK;
        else if (stab_cnt == STAB_LAST) state_nxt = RUN;
      end
      RUN:       if (!lock_s) state_nxt = WAIT_LOCK;
      default:   state_nxt = WAIT_LOCK;
    endcase
  end

  always_comb begin
    run     = (state == RUN);
    ready_o = run;
  end

  // Counter is only live while staying in STABLE; any other path restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
    end else if (state == STABLE && state_nxt == STABLE) begin
      stab_cnt <= stab_cnt + 1'b1;
    end else begin
      stab_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              lock_lost_o <= 1'b0;
    else if (run && !lock_s) lock_lost_o <= 1'b1;
  end

  // ---------------- rate update slot ----------------
  assign cfg_ready = !pend_v;

  // Out-of-range channel numbers complete the handshake but never occupy the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v   <= 1'b0;
      pend_ch  <= '0;
      pend_inc <= '0;
    end else if (pend_v) begin
      if (|apply) pend_v <= 1'b0;
    end else if (cfg_valid && ({1'b0, cfg_ch} < N_CH_L)) begin
      pend_v   <= 1'b1;
      pend_ch  <= cfg_ch;
      pend_inc <= cfg_inc;
    end
  end

  // ---------------- channels ----------------
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic             en_q;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    // Swap the increment only at a wrap (or when idle/stopped) so spacing never glitches.
    assign apply[i] = pend_v && (pend_ch == 3'(i)) &&
                      (!run || sum[ACC_W] || (inc_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        en_q  <= 1'b0;
        inc_q <= INC_INIT[i*ACC_W +: ACC_W];
      end else begin
        if (run) begin
          acc_q <= sum[ACC_W-1:0];
          en_q  <= sum[ACC_W];
        end else begin
          acc_q <= '0;
          en_q  <= 1'b0;
        end
        if (apply[i]) inc_q <= pend_inc;
      end
    end

    assign en_o[i] = en_q;

`ifdef CLK_EN_GEN_SQUARE_EN
    logic sq_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sq_q <= 1'b0;
      else        sq_q <= run ? sum[ACC_W-1] : 1'b0;
    end

    assign sq_o[i] = sq_q;
`endif
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Randomised self-checking bench for clk_en_gen against a phase-arithmetic reference model.
// Exercises sq_o as well when built with CLK_EN_GEN_SQUARE_EN.
module tb_clk_en_gen;

  localparam int N_CH        = 2;
  localparam int ACC_W       = 4;
  localparam int LOCK_STABLE = 8;
  localparam int MOD         = 1 << ACC_W;
  localparam logic [N_CH*ACC_W-1:0] INC_INIT = {4'd3, 4'd4};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pll_lock;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [N_CH-1:0]  en_o;
  logic             ready_o;
  logic             lock_lost_o;
`ifdef CLK_EN_GEN_SQUARE_EN
  logic [N_CH-1:0]  sq_o;
`endif

  always #5 clk = ~clk;

  clk_en_gen #(
    .N_CH        (N_CH),
    .ACC_W       (ACC_W),
    .LOCK_STABLE (LOCK_STABLE),
    .INC_INIT    (INC_INIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_inc     (cfg_inc),
    .en_o        (en_o),
    .ready_o     (ready_o),
    .lock_lost_o (lock_lost_o)
`ifdef CLK_EN_GEN_SQUARE_EN
    ,
    .sq_o        (sq_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lock history as a run-length count, channel phase as plain integers.
  bit              m_s1, m_s2, m_run, m_lost, m_pend, m_acc;
  int              m_hi, m_pch, m_pinc;
  int              m_ph  [N_CH];
  int              m_inc [N_CH];
  logic [N_CH-1:0] m_en, m_sq;

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_run = 0; m_lost = 0; m_pend = 0; m_acc = 0;
    m_hi = 0; m_pch = 0; m_pinc = 0;
    m_en = '0; m_sq = '0;
    for (int i = 0; i < N_CH; i++) begin
      m_ph[i]  = 0;
      m_inc[i] = int'((INC_INIT >> (i * ACC_W)) & (MOD - 1));
    end
  endfunction

  function automatic void model_step();
    bit lock_s = m_s2;
    bit run_now = m_run;
    bit carry [N_CH];
    m_s2 = m_s1;
    m_s1 = pll_lock;
    m_hi = lock_s ? m_hi + 1 : 0;
    for (int i = 0; i < N_CH; i++) begin
      carry[i] = 0;
      if (run_now) begin
        m_ph[i] += m_inc[i];
        if (m_ph[i] >= MOD) begin
          carry[i] = 1;
          m_ph[i] -= MOD;
        end
      end else begin
        m_ph[i] = 0;
      end
      m_en[i] = carry[i];
      m_sq[i] = run_now && (m_ph[i] >= MOD / 2);
    end
    m_acc = 0;
    if (m_pend) begin
      if (!run_now || carry[m_pch] || m_inc[m_pch] == 0) begin
        m_inc[m_pch] = m_pinc;
        m_pend = 0;
      end
    end else if (cfg_valid) begin
      m_acc = 1;
      if (int'(cfg_ch) < N_CH) begin
        m_pend = 1;
        m_pch  = int'(cfg_ch);
        m_pinc = int'(cfg_inc);
      end
    end
    m_lost = m_lost || (run_now && !lock_s);
    m_run  = lock_s && (run_now || m_hi == LOCK_STABLE + 1);
  endfunction

  task automatic check_outputs();
    check("ready_o",     32'(ready_o),     32'(m_run));
    check("lock_lost_o", 32'(lock_lost_o), 32'(m_lost));
    check("cfg_ready",   32'(cfg_ready),   32'(!m_pend));
    check("en_o",        32'(en_o),        32'(m_en));
`ifdef CLK_EN_GEN_SQUARE_EN
    check("sq_o",        32'(sq_o),        32'(m_sq));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    pll_lock  = 1'b0;
    cfg_valid = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input int ch, input int inc, output int waited);
    cfg_ch    = 3'(ch);
    cfg_inc   = 4'(inc);
    cfg_valid = 1'b1;
    waited    = 0;
    do begin
      tick();
      waited++;
    end while (!m_acc && waited < 50);
    if (!m_acc) check("cfg_accept_timeout", 32'(waited), 32'd0);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_slot_free();
    int n = 0;
    while (!cfg_ready && n < 40) begin
      tick();
      n++;
    end
    check("slot_free", 32'(cfg_ready), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready_o && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(ready_o), 32'd1);
  endtask

  task automatic count_pulses(input int cycles, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      c0 += int'(en_o[0]);
      c1 += int'(en_o[1]);
    end
  endtask

  initial begin
    int ready_edge, c0, c1, w, drop_cnt;

    rst_n = 1'b0; pll_lock = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clean start-up: ready after edge LOCK_STABLE+2.
    pll_lock = 1'b1;
    ready_edge = -1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (ready_o && ready_edge < 0) ready_edge = e;
    end
    check("startup_edge", 32'(ready_edge), 32'(LOCK_STABLE + 2));

    // One-cycle lock glitch at edge 5 restarts the stability window.
    do_reset();
    ready_edge = -1;
    for (int e = 0; e < 30; e++) begin
      pll_lock = (e != 5);
      tick();
      if (ready_o && ready_edge < 0) ready_edge = e;
    end
    check("glitch_startup_edge", 32'(ready_edge), 32'(6 + LOCK_STABLE + 2));

    count_pulses(48, c0, c1);
    check("ch0_pulses_inc4", 32'(c0), 32'd12);
    check("ch1_pulses_inc3", 32'(c1), 32'd9);

    // Reprogram ch0 to inc=8: spacing becomes 2 once the slot frees.
    send(0, 8, w);
    wait_slot_free();
    count_pulses(32, c0, c1);
    check("ch0_pulses_inc8", 32'(c0), 32'd16);

    // Out-of-range channel is swallowed; ch0 rate must not change.
    send(5, 1, w);
    check("oob_ready", 32'(cfg_ready), 32'd1);
    count_pulses(32, c0, c1);
    check("ch0_after_oob", 32'(c0), 32'd16);

    // Back-to-back updates to a stopped channel apply one cycle after acceptance.
    send(1, 0, w);
    send(1, 0, w);
    send(1, 7, w);
    check("b2b_wait", 32'(w), 32'd2);
    wait_slot_free();

    // Randomised traffic with occasional short lock losses.
    drop_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!cfg_valid && $urandom_range(3) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = ($urandom_range(7) == 0) ? 3'(2 + $urandom_range(5)) : 3'($urandom_range(1));
        cfg_inc   = 4'($urandom_range(15));
      end
      if (drop_cnt > 0) begin
        drop_cnt--;
        pll_lock = 1'b0;
      end else begin
        pll_lock = 1'b1;
        if ($urandom_range(399) == 0) drop_cnt = $urandom_range(4, 1);
      end
      tick();
      if (m_acc) cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;
    pll_lock  = 1'b1;
    wait_ready("relock_before_loss");

    // Lock loss in RUN: quiet and flagged after edge 3, sticky across re-lock.
    pll_lock = 1'b0;
    for (int e = 0; e < 4; e++) tick();
    check("loss_en", 32'(en_o), 32'd0);
    check("loss_ready", 32'(ready_o), 32'd0);
    check("loss_flag", 32'(lock_lost_o), 32'd1);
    pll_lock = 1'b1;
    wait_ready("relock_ready");
    check("lost_sticky", 32'(lock_lost_o), 32'd1);

    // Asynchronous reset with an update pending: slot and rates return to reset values.
    send(0, 1, w);
    wait_slot_free();
    send(0, 2, w);
    do_reset();
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_lost", 32'(lock_lost_o), 32'd0);
    pll_lock = 1'b1;
    wait_ready("post_reset_ready");
    count_pulses(48, c0, c1);
    check("post_reset_ch0", 32'(c0), 32'd12);
    check("post_reset_ch1", 32'(c1), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
